// File: rtl/forwarding_unit_pkg.sv
// Shared pipeline constants: register-specifier width and EX operand-mux select codes.
package forwarding_unit_pkg;

  localparam int DEF_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/forwarding_unit_fwd_sel.sv
// Single-operand forwarding select: combinational, zero latency, no flow control.
module fwd_sel
  import forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_ex_mem_wr,
  input  logic [REG_ADDR_W-1:0] i_ex_mem_rd,
  input  logic                  i_mem_wb_wr,
  input  logic [REG_ADDR_W-1:0] i_mem_wb_rd,
  output logic [1:0]            o_sel
);

  logic w_hit_exmem;
  logic w_hit_memwb;

  // x0 is hardwired to zero, so a write to it must never be forwarded
  assign w_hit_exmem = i_ex_mem_wr && (i_ex_mem_rd != '0) && (i_ex_mem_rd == i_rs);
  assign w_hit_memwb = i_mem_wb_wr && (i_mem_wb_rd != '0) && (i_mem_wb_rd == i_rs);

  always_comb begin
    o_sel = FWD_RF;
    if (w_hit_exmem) begin
      o_sel = FWD_EXMEM;
    end else if (w_hit_memwb) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forwarding_unit_sat_cnt.sv
// Saturating event counter: one-edge update latency, holds at all-ones, cleared by sync reset.
module sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage data-hazard forwarding: selects are combinational (zero latency, no handshake);
// statistics counters are registered and saturate.
module forwarding_unit
  import forwarding_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2,
  input  logic                  ex_mem_RegWrite,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  mem_wb_RegWrite,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic [CNT_W-1:0]      fwd_exmem_cnt,
  output logic [CNT_W-1:0]      fwd_memwb_cnt
);

  logic [1:0] w_sel_a;
  logic [1:0] w_sel_b;
  logic       w_inc_exmem;
  logic       w_inc_memwb;

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .i_rs        (id_ex_rs1),
    .i_ex_mem_wr (ex_mem_RegWrite),
    .i_ex_mem_rd (ex_mem_rd),
    .i_mem_wb_wr (mem_wb_RegWrite),
    .i_mem_wb_rd (mem_wb_rd),
    .o_sel       (w_sel_a)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .i_rs        (id_ex_rs2),
    .i_ex_mem_wr (ex_mem_RegWrite),
    .i_ex_mem_rd (ex_mem_rd),
    .i_mem_wb_wr (mem_wb_RegWrite),
    .i_mem_wb_rd (mem_wb_rd),
    .o_sel       (w_sel_b)
  );

  // Pipeline state is not trustworthy during reset, so fall back to the register file
  assign ForwardA = reset ? FWD_RF : w_sel_a;
  assign ForwardB = reset ? FWD_RF : w_sel_b;

  assign w_inc_exmem = (ForwardA == FWD_EXMEM) || (ForwardB == FWD_EXMEM);
  assign w_inc_memwb = (ForwardA == FWD_MEMWB) || (ForwardB == FWD_MEMWB);

  sat_cnt #(.CNT_W(CNT_W)) u_cnt_exmem (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_inc_exmem),
    .o_cnt (fwd_exmem_cnt)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_cnt_memwb (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_inc_memwb),
    .o_cnt (fwd_memwb_cnt)
  );

endmodule

// File: tb/tb_forwarding_unit.sv
// Bench for forwarding_unit: directed literal checks plus random traffic against a rule-level model.
module tb_forwarding_unit;

  logic       clk;
  logic       reset;
  logic [4:0] rs1, rs2, ex_rd, wb_rd;
  logic       ex_rw, wb_rw;

  logic [1:0]  fa, fb, fa4, fb4;
  logic [31:0] cnt_ex, cnt_mw;
  logic [3:0]  cnt4_ex, cnt4_mw;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  longint m_ex, m_mw, m_ex4, m_mw4;
  bit     m_valid = 0;

  forwarding_unit dut (
    .clk(clk), .reset(reset),
    .id_ex_rs1(rs1), .id_ex_rs2(rs2),
    .ex_mem_RegWrite(ex_rw), .ex_mem_rd(ex_rd),
    .mem_wb_RegWrite(wb_rw), .mem_wb_rd(wb_rd),
    .ForwardA(fa), .ForwardB(fb),
    .fwd_exmem_cnt(cnt_ex), .fwd_memwb_cnt(cnt_mw)
  );

  forwarding_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .id_ex_rs1(rs1), .id_ex_rs2(rs2),
    .ex_mem_RegWrite(ex_rw), .ex_mem_rd(ex_rd),
    .mem_wb_RegWrite(wb_rw), .mem_wb_rd(wb_rd),
    .ForwardA(fa4), .ForwardB(fb4),
    .fwd_exmem_cnt(cnt4_ex), .fwd_memwb_cnt(cnt4_mw)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_sel(input logic rst, input logic [4:0] rs,
                                         input logic w1, input logic [4:0] d1,
                                         input logic w2, input logic [4:0] d2);
    if (rst) return 2'b00;
    if (w1 && d1 != 0 && d1 == rs) return 2'b10;
    if (w2 && d2 != 0 && d2 == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Model counters advance on the edge from the rules, not from DUT outputs
  always @(posedge clk) begin
    logic [1:0] ea, eb;
    ea = exp_sel(reset, rs1, ex_rw, ex_rd, wb_rw, wb_rd);
    eb = exp_sel(reset, rs2, ex_rw, ex_rd, wb_rw, wb_rd);
    if (reset) begin
      m_ex = 0; m_mw = 0; m_ex4 = 0; m_mw4 = 0;
      m_valid = 1;
    end else begin
      if (ea == 2'b10 || eb == 2'b10) begin
        if (m_ex < 64'hFFFF_FFFF) m_ex++;
        if (m_ex4 < 15) m_ex4++;
      end
      if (ea == 2'b01 || eb == 2'b01) begin
        if (m_mw < 64'hFFFF_FFFF) m_mw++;
        if (m_mw4 < 15) m_mw4++;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [1:0] ea, eb;
    ea = exp_sel(reset, rs1, ex_rw, ex_rd, wb_rw, wb_rd);
    eb = exp_sel(reset, rs2, ex_rw, ex_rd, wb_rw, wb_rd);
    chk("model_fwdA", fa, ea);
    chk("model_fwdB", fb, eb);
    chk("model_fwdA_w4", fa4, ea);
    chk("model_fwdB_w4", fb4, eb);
    if (m_valid) begin
      chk("model_cnt_exmem", cnt_ex, m_ex);
      chk("model_cnt_memwb", cnt_mw, m_mw);
      chk("model_cnt4_exmem", cnt4_ex, m_ex4);
      chk("model_cnt4_memwb", cnt4_mw, m_mw4);
    end
  end

  // Inputs change just after the edge; checks follow at the next falling edge
  task automatic step(input logic rst, input logic [4:0] a, input logic [4:0] b,
                      input logic w1, input logic [4:0] d1,
                      input logic w2, input logic [4:0] d2);
    @(posedge clk);
    #1;
    reset = rst; rs1 = a; rs2 = b;
    ex_rw = w1; ex_rd = d1; wb_rw = w2; wb_rd = d2;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1; rs1 = 0; rs2 = 0; ex_rw = 0; ex_rd = 0; wb_rw = 0; wb_rd = 0;

    // Selects forced to 00 while reset even though inputs match
    step(1, 5'd3, 5'd4, 1, 5'd3, 1, 5'd4);
    chk("reset_fwdA", fa, 0);
    chk("reset_fwdB", fb, 0);
    step(1, 5'd3, 5'd4, 1, 5'd3, 1, 5'd4);
    chk("reset_cnt_exmem", cnt_ex, 0);
    chk("reset_cnt_memwb", cnt_mw, 0);

    step(0, 5'd1, 5'd2, 1, 5'd3, 1, 5'd4);
    chk("nomatch_fwdA", fa, 2'b00);
    chk("nomatch_fwdB", fb, 2'b00);

    step(0, 5'd3, 5'd4, 1, 5'd3, 1, 5'd4);
    chk("split_fwdA", fa, 2'b10);
    chk("split_fwdB", fb, 2'b01);
    chk("nomatch_cnt_exmem", cnt_ex, 0);
    chk("nomatch_cnt_memwb", cnt_mw, 0);

    step(0, 5'd5, 5'd5, 1, 5'd5, 1, 5'd5);
    chk("prio_fwdA", fa, 2'b10);
    chk("prio_fwdB", fb, 2'b10);
    chk("split_cnt_exmem", cnt_ex, 1);
    chk("split_cnt_memwb", cnt_mw, 1);

    step(0, 5'd0, 5'd0, 1, 5'd0, 1, 5'd0);
    chk("x0_fwdA", fa, 2'b00);
    chk("x0_fwdB", fb, 2'b00);
    chk("prio_cnt_exmem", cnt_ex, 2);
    chk("prio_cnt_memwb", cnt_mw, 1);

    step(0, 5'd3, 5'd0, 0, 5'd3, 1, 5'd3);
    chk("rw_off_exmem_fwdA", fa, 2'b01);

    step(0, 5'd3, 5'd0, 0, 5'd3, 0, 5'd3);
    chk("rw_off_both_fwdA", fa, 2'b00);
    chk("rw_cnt_memwb", cnt_mw, 2);

    // Hold a double-forward pattern long enough to saturate the 4-bit counters
    for (int i = 0; i < 20; i++) step(0, 5'd3, 5'd4, 1, 5'd3, 1, 5'd4);
    step(0, 5'd1, 5'd2, 1, 5'd3, 1, 5'd4);
    chk("sat_cnt4_exmem", cnt4_ex, 15);
    chk("sat_cnt4_memwb", cnt4_mw, 15);
    chk("wide_cnt_exmem", cnt_ex, 22);
    chk("wide_cnt_memwb", cnt_mw, 22);

    // Mid-run reset: selects gated, counters cleared, decoding resumes immediately
    step(1, 5'd3, 5'd4, 1, 5'd3, 1, 5'd4);
    chk("midreset_fwdA", fa, 2'b00);
    step(0, 5'd3, 5'd4, 1, 5'd3, 1, 5'd4);
    chk("resume_fwdA", fa, 2'b10);
    chk("resume_fwdB", fb, 2'b01);
    chk("midreset_cnt4_exmem", cnt4_ex, 0);
    chk("midreset_cnt_memwb", cnt_mw, 0);
    step(0, 5'd1, 5'd2, 0, 5'd0, 0, 5'd0);
    chk("after_reset_cnt_exmem", cnt_ex, 1);

    // Random traffic over a small register range so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 3),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end

    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
